pc_gen: RTL and testbench
=========================

# pc_gen

Next-PC generator for the pipelined MIPS core, successor to the single-cycle PC unit. It owns the fetch PC register, adds a stall hold, a prioritised redirect from ID (jump) and EX (branch/jr resolution), trap vectoring with EPC capture, and per-stage kill outputs. Reset and trap vectors are parameters, and an optional direct-mapped branch target buffer predicts taken branches at fetch.

## Interface
- RESET_PC, 32'h00400000, PC loaded on reset
- ILLOP_PC, 32'h80000004, interrupt vector
- XADR_PC, 32'h80000008, exception vector
- BTB_DEPTH, 16, BTB entries; power of two, 2..256
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold PC (load-use / memory stall)
- id_jump  in  1  J/JAL decoded in ID
- id_jt  in  26  jump target field
- id_pc_plus4  in  32  PC+4 of the ID instruction
- ex_redirect  in  1  EX resolved flow differs from prediction (branch mispredict or jr)
- ex_target  in  32  correct next PC from EX
- ex_valid  in  1  EX holds a real instruction
- ex_pc  in  32  PC of the EX instruction
- exception  in  1  undefined opcode in EX
- interrupt  in  1  external interrupt, level
- btb_upd, btb_taken  in  1 each  BTB update strobe / resolved direction
- btb_target  in  32  resolved taken target
- pc  out  32  current fetch PC
- pc_plus4  out  32  pc + 4
- pred_taken  out  1  fetch instruction predicted taken
- epc  out  32  saved return PC
- kill_if, kill_id, kill_ex  out  1 each  squash that stage this cycle

## Operation
- Next-PC priority, highest first:
  1. exception & ex_valid -> XADR_PC.
  2. interrupt & ex_valid & ~pc[31] -> ILLOP_PC.
  3. ex_redirect -> ex_target.
  4. stall -> hold pc.
  5. id_jump -> {id_pc_plus4[31:28], id_jt, 2'b00}.
  6. BTB hit -> predicted target.
  7. Otherwise pc_plus4.
- Items 1–3 override stall; items 5–7 do not.
- Traps (1, 2): epc <= ex_pc. kill_if = kill_id = kill_ex = 1.
- ex_redirect: kill_if = kill_id = 1.
- id_jump accepted: kill_if = 1.
- An interrupt with ex_valid=0 or pc[31]=1 is not taken; it is held off while the level persists.
- Exception and interrupt in the same cycle: the exception wins, and the interrupt stays pending.
- pc_plus4 is a 32-bit add that wraps: 32'hFFFFFFFC -> 0.
- BTB, when compiled in:
  - Index is pc[IW+1:2] with IW = log2(BTB_DEPTH). Tag is pc[31:IW+2].
  - Each entry holds {valid, tag, target}.
  - Hit = valid & tag match on the current pc. pred_taken = hit & ~stall.
  - Update is keyed on ex_pc. btb_upd & btb_taken writes the entry with valid=1. btb_upd & ~btb_taken clears valid only on a tag match.
  - Update and lookup to the same index in one cycle: the lookup sees the old contents.

## Timing
- Reset values: pc = RESET_PC, epc = 0, all BTB valid bits = 0.
- With pc at its reset value, pc_plus4 = RESET_PC+4, pred_taken = 0, and the kill outputs are 0 while no redirect input is asserted.
- pc and epc are registers. pc_plus4, pred_taken and the kill outputs are combinational from the current pc and inputs. There are no combinational paths between the kill outputs.
- A redirect takes one cycle: the target appears on pc the edge after the request.
- BTB write is visible on the first lookup after the writing edge.
- Reset asserted mid-operation: pc, epc and the BTB valids clear immediately, with no dependence on clk.

## Configuration
- PC_BTB_EN defined: BTB storage and the prediction path are present.
- PC_BTB_EN undefined: no BTB storage. pred_taken is tied to 0, btb_* inputs are ignored, and step 6 of the priority never fires. The core relies on ex_redirect for every taken branch.

## Structure
- Package pc_pkg holds:
  - Vector defaults RESET_PC, ILLOP_PC, XADR_PC.
  - An enum for the next-PC source (TRAP_X, TRAP_I, EX_REDIR, HOLD, JUMP, PRED, SEQ).
  - An IW helper function.
- Sub-module pc_btb holds the storage, lookup, and update. It is instantiated only under PC_BTB_EN.

## Test plan
- Reset release: pc = 32'h00400000. After 3 free cycles pc = 32'h0040000C. epc = 0.
- stall=1 for 2 cycles at pc=32'h00400010: pc holds. ex_redirect to 32'h00400100 during the stall: next pc = 32'h00400100, kill_if = kill_id = 1.
- id_jump with id_pc_plus4 = 32'h00400024 and id_jt = 26'h0100040: next pc = 32'h00400100, kill_if = 1 only.
- exception and interrupt together with ex_valid=1 and ex_pc = 32'h00400050: pc -> 32'h80000008, epc = 32'h00400050, all kills = 1. The next cycle, with pc[31]=1, the still-asserted interrupt is ignored.
- interrupt with ex_valid=0: no redirect. When ex_valid rises with ex_pc = 32'h00400060: pc -> 32'h80000004, epc = 32'h00400060.
- PC_BTB_EN: update with ex_pc = 32'h00400080, taken, target 32'h00400200. The next fetch of 32'h00400080 gives pred_taken=1, and the following pc = 32'h00400200. A not-taken update then clears the entry, and the next fetch gives pred_taken=0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared vector defaults, next-PC source enum and BTB index-width helper for pc_gen.
package pc_pkg;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] XADR_PC  = 32'h8000_0008;
  typedef enum logic [2:0] {TRAP_X, TRAP_I, EX_REDIR, HOLD, JUMP, PRED, SEQ} src_e;
  function automatic int iw(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/pc_btb.sv
// pc_btb: direct-mapped branch target buffer with async-cleared valids.
// Ports: clk_i, rst_ni (async active-low), pc_i (lookup PC), upd_i/taken_i/upd_pc_i/target_i
// (update keyed on the resolving instruction's PC), hit_o/target_o (lookup result).
import pc_pkg::*;
module pc_btb #(
  parameter int DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] pc_i,
  input  logic        upd_i,
  input  logic        taken_i,
  input  logic [31:0] upd_pc_i,
  input  logic [31:0] target_i,
  output logic        hit_o,
  output logic [31:0] target_o
);
  localparam int IW = iw(DEPTH);
  localparam int TW = 30 - IW;
  logic [DEPTH-1:0] valid_q;
  logic [TW-1:0]    tag_q [DEPTH];
  logic [31:0]      tgt_q [DEPTH];
  logic [IW-1:0]    rd_idx, wr_idx;
  logic [TW-1:0]    rd_tag, wr_tag;
  logic             unused_lsb;
  assign rd_idx     = pc_i[IW+1:2];
  assign rd_tag     = pc_i[31:IW+2];
  assign wr_idx     = upd_pc_i[IW+1:2];
  assign wr_tag     = upd_pc_i[31:IW+2];
  assign unused_lsb = ^{pc_i[1:0], upd_pc_i[1:0]};
  // Lookup reads the registered arrays, so a same-cycle update is seen only next cycle.
  assign hit_o    = valid_q[rd_idx] & (tag_q[rd_idx] == rd_tag);
  assign target_o = tgt_q[rd_idx];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) valid_q <= '0;
    else if (upd_i & taken_i) valid_q[wr_idx] <= 1'b1;
    else if (upd_i & (tag_q[wr_idx] == wr_tag)) valid_q[wr_idx] <= 1'b0;
  // Tag/target need no reset: they are qualified by valid_q.
  always_ff @(posedge clk_i)
    if (upd_i & taken_i) begin
      tag_q[wr_idx] <= wr_tag;
      tgt_q[wr_idx] <= target_i;
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: pipelined next-PC generator with stall, ID jump, EX redirect, trap vectoring and kills.
// Ports: clk_i, rst_ni (async active-low); stall_i; id_jump_i/id_jt_i/id_pc_plus4_i (ID jump);
// ex_redirect_i/ex_target_i (EX redirect); ex_valid_i/ex_pc_i/exception_i/interrupt_i (traps);
// btb_upd_i/btb_taken_i/btb_target_i (BTB update); pc_o, pc_plus4_o, pred_taken_o, epc_o,
// kill_if_o/kill_id_o/kill_ex_o. Define PC_BTB_EN to build in the branch target buffer.
import pc_pkg::*;
module pc_gen #(
  parameter logic [31:0] RESET_PC  = pc_pkg::RESET_PC,
  parameter logic [31:0] ILLOP_PC  = pc_pkg::ILLOP_PC,
  parameter logic [31:0] XADR_PC   = pc_pkg::XADR_PC,
  parameter int          BTB_DEPTH = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        id_jump_i,
  input  logic [25:0] id_jt_i,
  input  logic [31:0] id_pc_plus4_i,
  input  logic        ex_redirect_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        exception_i,
  input  logic        interrupt_i,
  input  logic        btb_upd_i,
  input  logic        btb_taken_i,
  input  logic [31:0] btb_target_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        pred_taken_o,
  output logic [31:0] epc_o,
  output logic        kill_if_o,
  output logic        kill_id_o,
  output logic        kill_ex_o
);
  logic [31:0] pc_q, pc_d, epc_q, pred_tgt;
  logic        hit, trap_x, trap_i, trap;
  src_e        src;
  logic        unused_in;
`ifdef PC_BTB_EN
  pc_btb #(.DEPTH(BTB_DEPTH)) u_btb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .pc_i     (pc_q),
    .upd_i    (btb_upd_i),
    .taken_i  (btb_taken_i),
    .upd_pc_i (ex_pc_i),
    .target_i (btb_target_i),
    .hit_o    (hit),
    .target_o (pred_tgt)
  );
  assign unused_in = ^id_pc_plus4_i[27:0];
`else
  assign hit       = 1'b0;
  assign pred_tgt  = '0;
  assign unused_in = ^{id_pc_plus4_i[27:0], btb_upd_i, btb_taken_i, btb_target_i};
`endif
  assign trap_x = exception_i & ex_valid_i;
  // Interrupts are masked while fetching from kernel space and lose to a concurrent exception;
  // the level input keeps the request pending.
  assign trap_i = interrupt_i & ex_valid_i & ~pc_q[31] & ~trap_x;
  assign trap   = trap_x | trap_i;
  always_comb begin
    src  = trap_x        ? TRAP_X   :
           trap_i        ? TRAP_I   :
           ex_redirect_i ? EX_REDIR :
           stall_i       ? HOLD     :
           id_jump_i     ? JUMP     :
           hit           ? PRED     : SEQ;
    pc_d = src == TRAP_X   ? XADR_PC                              :
           src == TRAP_I   ? ILLOP_PC                             :
           src == EX_REDIR ? ex_target_i                          :
           src == HOLD     ? pc_q                                 :
           src == JUMP     ? {id_pc_plus4_i[31:28], id_jt_i, 2'b00} :
           src == PRED     ? pred_tgt                             : pc_plus4_o;
  end
  assign pc_plus4_o   = pc_q + 32'd4;
  assign pred_taken_o = hit & ~stall_i;
  assign kill_ex_o    = trap;
  assign kill_id_o    = trap | ex_redirect_i;
  assign kill_if_o    = trap | ex_redirect_i | (id_jump_i & ~stall_i);
  assign pc_o         = pc_q;
  assign epc_o        = epc_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      pc_q  <= RESET_PC;
      epc_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (trap) epc_q <= ex_pc_i;
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen.
module tb_pc_gen;
  logic        clk = 1'b0, rst_ni = 1'b0;
  logic        stall = 0, id_jump = 0, ex_redirect = 0, ex_valid = 0, exception = 0, interrupt = 0;
  logic        btb_upd = 0, btb_taken = 0;
  logic [25:0] id_jt = '0;
  logic [31:0] id_pc_plus4 = '0, ex_target = '0, ex_pc = '0, btb_target = '0;
  logic [31:0] pc, pc_plus4, epc;
  logic        pred_taken, kill_if, kill_id, kill_ex;
  int          checks = 0, errors = 0;
  logic        btb_on;

  pc_gen dut (
    .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall), .id_jump_i(id_jump), .id_jt_i(id_jt),
    .id_pc_plus4_i(id_pc_plus4), .ex_redirect_i(ex_redirect), .ex_target_i(ex_target),
    .ex_valid_i(ex_valid), .ex_pc_i(ex_pc), .exception_i(exception), .interrupt_i(interrupt),
    .btb_upd_i(btb_upd), .btb_taken_i(btb_taken), .btb_target_i(btb_target),
    .pc_o(pc), .pc_plus4_o(pc_plus4), .pred_taken_o(pred_taken), .epc_o(epc),
    .kill_if_o(kill_if), .kill_id_o(kill_id), .kill_ex_o(kill_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kills(input string tag, input logic [2:0] exp);
    #1;
    chk(tag, {29'd0, kill_if, kill_id, kill_ex}, {29'd0, exp});
  endtask

  initial begin
`ifdef PC_BTB_EN
    btb_on = 1'b1;
`else
    btb_on = 1'b0;
`endif
    #12;
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_epc", epc, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h0040_0004);
    chk("rst_pred", {31'd0, pred_taken}, 32'd0);
    kills("rst_kill", 3'b000);
    rst_ni = 1'b1;
    repeat (3) step();
    chk("free3", pc, 32'h0040_000C);
    chk("free3_epc", epc, 32'h0);
    step();
    chk("seq", pc, 32'h0040_0010);
    stall = 1;
    kills("stall_kill", 3'b000);
    step();
    chk("stall1", pc, 32'h0040_0010);
    id_jump = 1; id_pc_plus4 = 32'h0040_0024; id_jt = 26'h0100040;
    kills("stall_jump_kill", 3'b000);
    step();
    chk("stall2_jump", pc, 32'h0040_0010);
    id_jump = 0;
    ex_redirect = 1; ex_target = 32'h0040_0100;
    kills("redir_kill", 3'b110);
    step();
    chk("redir", pc, 32'h0040_0100);
    stall = 0; ex_redirect = 0;
    step();
    chk("seq2", pc, 32'h0040_0104);
    id_jump = 1;
    kills("jump_kill", 3'b100);
    step();
    chk("jump", pc, 32'h0040_0100);
    id_jump = 0;
    ex_valid = 1; ex_pc = 32'h0040_0050; exception = 1; interrupt = 1;
    kills("trap_kill", 3'b111);
    step();
    chk("trapx_pc", pc, 32'h8000_0008);
    chk("trapx_epc", epc, 32'h0040_0050);
    exception = 0; ex_pc = 32'h0040_0099;
    kills("int_masked_kill", 3'b000);
    step();
    chk("int_masked_pc", pc, 32'h8000_000C);
    chk("int_masked_epc", epc, 32'h0040_0050);
    interrupt = 0; ex_valid = 0;
    ex_redirect = 1; ex_target = 32'h0040_0040;
    step();
    ex_redirect = 0;
    chk("ret_user", pc, 32'h0040_0040);
    interrupt = 1;
    kills("int_noval_kill", 3'b000);
    step();
    chk("int_noval_pc", pc, 32'h0040_0044);
    ex_valid = 1; ex_pc = 32'h0040_0060;
    kills("int_kill", 3'b111);
    step();
    chk("int_pc", pc, 32'h8000_0004);
    chk("int_epc", epc, 32'h0040_0060);
    interrupt = 0; ex_valid = 0;
    ex_redirect = 1; ex_target = 32'hFFFF_FFFC;
    step();
    ex_redirect = 0;
    chk("wrap_pc4", pc_plus4, 32'h0);
    step();
    chk("wrap_pc", pc, 32'h0);
    #3 rst_ni = 0;
    #1;
    chk("async_pc", pc, 32'h0040_0000);
    chk("async_epc", epc, 32'h0);
    @(negedge clk);
    rst_ni = 1;
    step();
    btb_upd = 1; btb_taken = 1; ex_pc = 32'h0040_0080; btb_target = 32'h0040_0200;
    step();
    btb_upd = 0;
    ex_redirect = 1; ex_target = 32'h0040_0080;
    step();
    ex_redirect = 0;
    #1;
    chk("btb_pred", {31'd0, pred_taken}, {31'd0, btb_on});
    step();
    chk("btb_tgt", pc, btb_on ? 32'h0040_0200 : 32'h0040_0084);
    btb_upd = 1; btb_taken = 0;
    step();
    btb_upd = 0;
    ex_redirect = 1;
    step();
    ex_redirect = 0;
    #1;
    chk("btb_clr_pred", {31'd0, pred_taken}, 32'd0);
    step();
    chk("btb_clr_pc", pc, 32'h0040_0084);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
